// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: each channel toggles clk_out every H[c] enabled cycles.
// Optional macro PROG_CLK_DIVIDER_TICK_EN adds a registered per-channel toggle pulse output.
module prog_clk_divider #(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_WIDTH    = 26,
    parameter int unsigned DEFAULT_HALF = 2**25,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync_all,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [CNT_WIDTH-1:0] wr_half,
    output logic [NUM_CH-1:0]    clk_out
`ifdef PROG_CLK_DIVIDER_TICK_EN
    ,
    output logic [NUM_CH-1:0]    tick
`endif
);

    localparam logic [CNT_WIDTH-1:0] DEF_HALF = CNT_WIDTH'(DEFAULT_HALF);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] half_q [NUM_CH];
    logic [CNT_WIDTH-1:0] half_d [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]    clk_out_q;
    logic [NUM_CH-1:0]    clk_out_d;
    logic [NUM_CH-1:0]    tick_d;
    logic                 wr_valid;

    // Out-of-range channel indices (possible when NUM_CH is not a power of two) are dropped.
    assign wr_valid = wr_en && (int'(wr_ch) < NUM_CH);

    always_comb begin
        half_d    = half_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            // A restart (write or sync) takes precedence over a wrap, so it never toggles.
            if (sync_all || (wr_valid && (int'(wr_ch) == c))) begin
                if (wr_valid && (int'(wr_ch) == c)) begin
                    half_d[c] = wr_half;
                end
                cnt_d[c]     = '0;
                clk_out_d[c] = 1'b0;
            end else if (half_q[c] == '0) begin
                cnt_d[c]     = '0;
                clk_out_d[c] = 1'b0;
            end else if (en[c]) begin
                if (cnt_q[c] == half_q[c] - ONE) begin
                    cnt_d[c]     = '0;
                    clk_out_d[c] = ~clk_out_q[c];
                    tick_d[c]    = 1'b1;
                end else begin
                    cnt_d[c] = cnt_q[c] + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            half_q    <= '{default: DEF_HALF};
            cnt_q     <= '{default: '0};
            clk_out_q <= '0;
        end else begin
            half_q    <= half_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

`ifdef PROG_CLK_DIVIDER_TICK_EN
    logic [NUM_CH-1:0] tick_q;

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`else
    logic unused_tick;
    assign unused_tick = ^tick_d;
`endif

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomised self-checking bench for prog_clk_divider (4-channel and 3-channel instances).
// The reference model tracks enabled cycles since the last restart and derives outputs arithmetically.
module tb_prog_clk_divider;

    localparam int CW = 8;
    localparam int DH = 4;

    logic          clk_100mhz = 1'b0;
    logic          rst;
    logic          sync_all;
    logic          wr_en;
    logic [3:0]    en;
    logic [1:0]    wr_ch;
    logic [CW-1:0] wr_half;
    logic [3:0]    clk_out4;
    logic [2:0]    clk_out3;
`ifdef PROG_CLK_DIVIDER_TICK_EN
    logic [3:0]    tick4;
    logic [2:0]    tick3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_h  [2][4];
    int m_el [2][4];
    bit m_tk [2][4];

    always #5 clk_100mhz = ~clk_100mhz;

    prog_clk_divider #(.NUM_CH(4), .CNT_WIDTH(CW), .DEFAULT_HALF(DH)) dut4 (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .en         (en),
        .sync_all   (sync_all),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_half    (wr_half),
        .clk_out    (clk_out4)
`ifdef PROG_CLK_DIVIDER_TICK_EN
        ,
        .tick       (tick4)
`endif
    );

    prog_clk_divider #(.NUM_CH(3), .CNT_WIDTH(CW), .DEFAULT_HALF(DH)) dut3 (
        .clk_100mhz (clk_100mhz),
        .rst        (rst),
        .en         (en[2:0]),
        .sync_all   (sync_all),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_half    (wr_half),
        .clk_out    (clk_out3)
`ifdef PROG_CLK_DIVIDER_TICK_EN
        ,
        .tick       (tick3)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Output level is the parity of completed half-periods since the last restart.
    function automatic logic [3:0] expOut(input int d);
        logic [3:0] r = '0;
        for (int c = 0; c < ((d == 0) ? 4 : 3); c++) begin
            r[c] = (m_h[d][c] == 0) ? 1'b0 : (((m_el[d][c] / m_h[d][c]) % 2) == 1);
        end
        return r;
    endfunction

    function automatic logic [3:0] expTick(input int d);
        logic [3:0] r = '0;
        for (int c = 0; c < ((d == 0) ? 4 : 3); c++) begin
            r[c] = m_tk[d][c];
        end
        return r;
    endfunction

    task automatic modelEdge();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < ((d == 0) ? 4 : 3); c++) begin
                bit hit = wr_en && (int'(wr_ch) == c);
                m_tk[d][c] = 1'b0;
                if (rst) begin
                    m_h[d][c]  = DH;
                    m_el[d][c] = 0;
                end else if (sync_all || hit) begin
                    if (hit) m_h[d][c] = int'(wr_half);
                    m_el[d][c] = 0;
                end else if (m_h[d][c] == 0) begin
                    m_el[d][c] = 0;
                end else if (en[c]) begin
                    m_el[d][c]++;
                    m_tk[d][c] = (m_el[d][c] % m_h[d][c]) == 0;
                end
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk_100mhz);
        modelEdge();
        @(negedge clk_100mhz);
        checkOutput("clk_out4", 32'(clk_out4), 32'(expOut(0)));
        checkOutput("clk_out3", 32'(clk_out3), 32'(expOut(1)));
`ifdef PROG_CLK_DIVIDER_TICK_EN
        checkOutput("tick4", 32'(tick4), 32'(expTick(0)));
        checkOutput("tick3", 32'(tick3), 32'(expTick(1)));
`endif
    endtask

    task automatic writeHalf(input int ch, input int h);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_half = CW'(h);
        applyStimulus();
        wr_en   = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int ticks;
        int k;
        rst = 1'b1; sync_all = 1'b0; wr_en = 1'b0; en = 4'h0; wr_ch = '0; wr_half = '0;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("rst_out4", 32'(clk_out4), 32'h0);

        // Default half-period of 4: rise after 4 cycles, period 8.
        rst = 1'b0;
        en  = 4'hF;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus();
            checkOutput("period8", 32'(clk_out4), (((i / 4) % 2) == 1) ? 32'hF : 32'h0);
        end

        writeHalf(2, 1);
        checkOutput("wr_mid_low", 32'(clk_out4[2]), 32'h0);
        applyStimulus();
        checkOutput("wr_mid_t1", 32'(clk_out4[2]), 32'h1);
        applyStimulus();
        checkOutput("wr_mid_t2", 32'(clk_out4[2]), 32'h0);

        // Align channel 1 to high with two cycles already counted, then freeze it.
        k = 0;
        while ((m_el[0][1] % 8) != 6 && k < 16) begin
            applyStimulus();
            k++;
        end
        checkOutput("gate_align", 32'(m_el[0][1] % 8), 32'd6);
        en[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("gate_hold", 32'(clk_out4[1]), 32'h1);
        end
        en[1] = 1'b1;
        applyStimulus();
        checkOutput("gate_resume", 32'(clk_out4[1]), 32'h1);
        applyStimulus();
        checkOutput("gate_toggle", 32'(clk_out4[1]), 32'h0);

        writeHalf(0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput("stop_ch0", 32'(clk_out4[0]), 32'h0);
        end
        writeHalf(3, 7);
        checkOutput("oor_h3", 32'(m_h[1][2]), 32'd1);

        writeHalf(0, 4);
        writeHalf(2, 4);
        sync_all = 1'b1;
        writeHalf(3, 2);
        sync_all = 1'b0;
        checkOutput("sync_out4", 32'(clk_out4), 32'h0);
        checkOutput("sync_out3", 32'(clk_out3), 32'h0);
        ticks = 0;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus();
            checkOutput("sync_ph4", 32'(clk_out4),
                        {28'h0, 1'(((i / 2) % 2) == 1), {3{1'(((i / 4) % 2) == 1)}}});
            checkOutput("sync_ph3", 32'(clk_out3), (((i / 4) % 2) == 1) ? 32'h7 : 32'h0);
`ifdef PROG_CLK_DIVIDER_TICK_EN
            ticks += int'(tick4[0]);
`endif
        end
`ifdef PROG_CLK_DIVIDER_TICK_EN
        checkOutput("ticks_per_period", 32'(ticks), 32'd2);
`endif

        // Random phase: small half-periods dominate so toggles are frequent; 255 exercises the full width.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            sync_all = ($urandom_range(0, 49) == 0);
            wr_en    = ($urandom_range(0, 19) == 0);
            wr_ch    = 2'($urandom_range(0, 3));
            wr_half  = ($urandom_range(0, 9) == 0) ? CW'(255) : CW'($urandom_range(0, 6));
            en       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
